calc_port_responder: RTL and testbench
======================================

# calc_port_responder

Synthesizable responder for one calculator port. It accepts 70-bit request packets from the stimulus side, executes add/subtract/shift commands, and returns one 49-bit response packet per valid command. The response packet layout is the same as the per-port expected-result packet, so the scoreboard compares the two words directly. Four instances, one per port, sit between the port request drivers and the response monitors.

## Interface
Parameters:
- PORT_ID, 8'h31: ASCII port number ('1'..'4'); placed in rsp_paket[48:41].
- FIFO_DEPTH, 4: request buffer depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request packet present.
- req_ready  out  1  buffer can accept a request.
- req_paket  in  70  {tag[69:68], cmd[67:64], data1[63:32], data2[31:0]}.
- rsp_valid  out  1  response packet present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_paket  out  49  {port[48:41], cmd[40:37], tag[36:35], resp[34:33], result[32:1], flow[0]}.

## Operation
- Request handshake: a request is accepted on any edge where req_valid && req_ready. Accepted requests are pushed into the request FIFO.
- req_ready = !full && !reset.
- Commands:
  - 1 (ADD): {flow, sum} = data1 + data2, 33-bit unsigned.
    - flow=1: resp=2, result=0.
    - Otherwise: resp=1, result=sum.
  - 2 (SUB): unsigned compare.
    - data1 < data2: resp=2, result=0, flow=1.
    - Otherwise: result = data1 - data2, resp=1, flow=0.
  - 5 (SHL): result = data1 << data2[4:0], resp=1, flow=0. data2[31:5] is ignored.
  - 6 (SHR): logical right shift. Otherwise identical to SHL.
  - 0 (NOP): popped and discarded. No response is produced.
  - All other values: resp=2, result=0, flow=0. A response is still produced.
- Every response echoes the request's cmd and tag. port = PORT_ID.
- Responses are returned strictly in request order. Only one command is in flight at a time.
- FSM states: IDLE, EXEC, SHIFT, RESP.
  - IDLE: if the FIFO is non-empty, pop into the operand registers.
    - NOP: stay in IDLE.
    - cmd 5 or 6: go to SHIFT, with counter = data2[4:0].
    - Anything else: go to EXEC.
  - EXEC: compute the result, load the response register, go to RESP.
  - SHIFT: iterative shifter.
    - counter != 0: shift the work register by 1 bit in the command's direction and decrement the counter.
    - counter == 0: load the response register and go to RESP.
  - RESP: rsp_valid=1, with rsp_paket held stable until rsp_ready. On handshake, go to IDLE.

## Timing
- Reset values:
  - rsp_valid=0, rsp_paket=0.
  - req_ready=0 while reset is high. It is 1 on the first cycle after reset (FIFO empty).
  - FSM=IDLE. FIFO pointers and count = 0.
- Latency from the accept edge N to rsp_valid high:
  - ADD, SUB, invalid commands: cycle N+3.
  - SHL/SHR with amount k: cycle N+3+k. A shift of 0 costs one SHIFT cycle, so latency is N+3.
- A NOP occupies IDLE for one cycle.
- Back-pressure: the FSM stalls in RESP indefinitely. The FIFO keeps accepting requests until full.
- Full FIFO: req_ready=0 even if a pop happens in the same cycle. There is no full-bypass.
- A push and a pop in the same cycle with the FIFO neither empty nor full: count is unchanged and pointers wrap modulo FIFO_DEPTH.
- rsp_paket changes only on the cycle rsp_valid rises. It never changes while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation:
  - FIFO contents and any in-flight command are dropped.
  - rsp_valid falls on the reset edge.
  - No response is emitted for dropped requests.

## Structure
- Package calc_pkg holds:
  - cmd constants: CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6.
  - resp constants: RESP_NONE=0, RESP_OK=1, RESP_ERR=2.
  - Packed struct typedefs req_pkt_t (70b) and rsp_pkt_t (49b).
  - FSM state enum.
- Sub-module calc_req_fifo: synchronous FIFO, parameterized by WIDTH and DEPTH, with full/empty outputs. It is instantiated once, with WIDTH=70.

## Test plan
- ADD: data1=32'h0000_0005, data2=32'h0000_0007, tag=2 -> rsp_paket = {8'h31, 4'h1, 2'd2, 2'd1, 32'h0000_000C, 1'b0}, rsp_valid high at N+3.
- ADD overflow and SUB underflow:
  - ADD FFFF_FFFF+1 -> resp=2, result=0, flow=1.
  - SUB 3-5 -> resp=2, result=0, flow=1.
  - SUB 5-3 -> resp=1, result=2.
- Shifts:
  - SHL data1=1, data2=32'h0000_0023 (amount 3) -> result=8, rsp_valid at N+6.
  - SHR data1=8000_0000, amount 31 -> result=1.
  - Shift amount 0 -> result=data1.
- Command filtering and ordering: send cmd 0, cmd 3, then ADD 1+1 (tags 0,1,2) -> exactly two responses, in order:
  - tag 1: resp=2, result=0.
  - tag 2: resp=1, result=2.
- Back-pressure: hold rsp_ready=0 and send 6 back-to-back requests.
  - req_ready drops after the FIFO fills (5 requests held: 4 in the FIFO plus 1 in flight).
  - rsp_paket stays stable while stalled.
  - After rsp_ready=1, all responses arrive in order.
- Reset mid-operation: assert reset during SHIFT of a 31-bit shift -> rsp_valid=0 on the next edge, no stale response afterwards, and a fresh ADD completes with normal latency.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator port responder: command and
// response codes, request/response packet layouts and the FSM state encoding.
package calc_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  tag;
    logic [3:0]  cmd;
    logic [31:0] data1;
    logic [31:0] data2;
  } req_pkt_t;

  typedef struct packed {
    logic [7:0]  port;
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [1:0]  resp;
    logic [31:0] result;
    logic        flow;
  } rsp_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } calc_state_e;

  function automatic rsp_pkt_t make_rsp(input logic [7:0] port, input logic [3:0] cmd,
                                        input logic [1:0] tag, input logic [1:0] resp,
                                        input logic [31:0] result, input logic flow);
    rsp_pkt_t r;
    r.port   = port;
    r.cmd    = cmd;
    r.tag    = tag;
    r.resp   = resp;
    r.result = result;
    r.flow   = flow;
    return r;
  endfunction

endpackage

// File: rtl/calc_req_fifo.sv
// Synchronous request FIFO with combinational read data at the head.
// Push is ignored when full and pop when empty; DEPTH must be a power of 2.
module calc_req_fifo #(
  parameter int WIDTH = 70,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/calc_port_responder.sv
// One calculator port: buffers requests, executes ADD/SUB/SHL/SHR one at a
// time and returns responses in order. Handshake: a beat transfers on a rising edge when valid && ready.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter logic [7:0] PORT_ID    = 8'h31,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [69:0] req_paket,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [48:0] rsp_paket,
  output calc_state_e state_dbg
);

  calc_state_e state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  tag_q, tag_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  rsp_pkt_t    rsp_q, rsp_d;

  logic        fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [69:0] fifo_rdata;
  req_pkt_t    head;
  logic [32:0] sum;

  assign req_ready = !fifo_full && !reset;
  assign fifo_push = req_valid && req_ready;
  assign head      = req_pkt_t'(fifo_rdata);
  assign sum       = {1'b0, a_q} + {1'b0, b_q};

  calc_req_fifo #(.WIDTH(70), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (req_paket),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    tag_d    = tag_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    rsp_d    = rsp_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = head.cmd;
          tag_d    = head.tag;
          a_d      = head.data1;
          b_d      = head.data2;
          cnt_d    = head.data2[4:0];
          if (head.cmd == CMD_NOP)                           state_d = ST_IDLE;
          else if (head.cmd == CMD_SHL || head.cmd == CMD_SHR) state_d = ST_SHIFT;
          else                                               state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cmd_q)
          CMD_ADD: begin
            if (sum[32]) rsp_d = make_rsp(PORT_ID, cmd_q, tag_q, RESP_ERR, 32'd0, 1'b1);
            else         rsp_d = make_rsp(PORT_ID, cmd_q, tag_q, RESP_OK, sum[31:0], 1'b0);
          end
          CMD_SUB: begin
            if (a_q < b_q) rsp_d = make_rsp(PORT_ID, cmd_q, tag_q, RESP_ERR, 32'd0, 1'b1);
            else           rsp_d = make_rsp(PORT_ID, cmd_q, tag_q, RESP_OK, a_q - b_q, 1'b0);
          end
          default: rsp_d = make_rsp(PORT_ID, cmd_q, tag_q, RESP_ERR, 32'd0, 1'b0);
        endcase
        state_d = ST_RESP;
      end
      ST_SHIFT: begin
        // One bit per cycle; a zero amount still spends one cycle here.
        if (cnt_q != 5'd0) begin
          a_d   = (cmd_q == CMD_SHL) ? (a_q << 1) : (a_q >> 1);
          cnt_d = cnt_q - 5'd1;
        end else begin
          rsp_d   = make_rsp(PORT_ID, cmd_q, tag_q, RESP_OK, a_q, 1'b0);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_paket = rsp_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder: a vector table for single commands
// plus hand-written sequences for filtering, back-pressure and mid-op reset.
module tb_calc_port_responder;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [69:0] req_paket;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [48:0] rsp_paket;
  calc_state_e state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [48:0] exp_q[$];
  logic [48:0] got_q[$];

  typedef struct {
    logic [1:0]  tag;
    logic [3:0]  cmd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  resp;
    logic [31:0] res;
    logic        flow;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  calc_port_responder #(.PORT_ID(8'h31), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_paket (req_paket),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_paket (rsp_paket),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // collect every completed response handshake
  always @(posedge clk) begin
    if (!reset && rsp_valid && rsp_ready) got_q.push_back(rsp_paket);
  end

  function automatic logic [48:0] exp_pkt(input logic [3:0] cmd, input logic [1:0] tag,
                                          input logic [1:0] resp, input logic [31:0] res,
                                          input logic flow);
    return {8'h31, cmd, tag, resp, res, flow};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [1:0] tag, input logic [3:0] cmd, input logic [31:0] d1,
                      input logic [31:0] d2, output bit ok);
    ok        = 1'b0;
    req_valid = 1'b1;
    req_paket = {tag, cmd, d1, d2};
    for (int i = 0; i < 300; i++) begin
      if (req_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bit ok;
    int lat;
    send(v.tag, v.cmd, v.d1, v.d2, ok);
    req_valid = 1'b0;
    chk({name, "_accept"}, 64'(ok), 64'd1);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(v.lat));
    chk({name, "_pkt"}, 64'(rsp_paket), 64'(exp_pkt(v.cmd, v.tag, v.resp, v.res, v.flow)));
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    logic [48:0] held;
    int waited;

    vecs[0]  = '{2'd2, 4'd1, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C, 1'b0, 3};
    vecs[1]  = '{2'd0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, 1'b1, 3};
    vecs[2]  = '{2'd1, 4'd2, 32'h0000_0003, 32'h0000_0005, 2'd2, 32'h0000_0000, 1'b1, 3};
    vecs[3]  = '{2'd3, 4'd2, 32'h0000_0005, 32'h0000_0003, 2'd1, 32'h0000_0002, 1'b0, 3};
    vecs[4]  = '{2'd1, 4'd5, 32'h0000_0001, 32'h0000_0023, 2'd1, 32'h0000_0008, 1'b0, 6};
    vecs[5]  = '{2'd2, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001, 1'b0, 34};
    vecs[6]  = '{2'd0, 4'd5, 32'hDEAD_BEEF, 32'h0000_0020, 2'd1, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[7]  = '{2'd3, 4'd7, 32'h0000_0011, 32'h0000_0022, 2'd2, 32'h0000_0000, 1'b0, 3};
    vecs[8]  = '{2'd1, 4'd1, 32'h1234_5678, 32'h1111_1111, 2'd1, 32'h2345_6789, 1'b0, 3};
    vecs[9]  = '{2'd2, 4'd6, 32'hF000_0000, 32'hFFFF_FFE4, 2'd1, 32'h0F00_0000, 1'b0, 7};
    vecs[10] = '{2'd3, 4'd5, 32'h8000_0001, 32'h0000_0001, 2'd1, 32'h0000_0002, 1'b0, 4};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_paket = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_paket", 64'(rsp_paket), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_req_ready", 64'(req_ready), 64'd1);
    chk("post_reset_state", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // NOP and invalid command filtering, order preserved
    got_q.delete();
    exp_q.delete();
    send(2'd0, 4'd0, 32'd0, 32'd0, ok);
    send(2'd1, 4'd3, 32'd9, 32'd9, ok);
    send(2'd2, 4'd1, 32'd1, 32'd1, ok);
    req_valid = 1'b0;
    exp_q.push_back(exp_pkt(4'd3, 2'd1, 2'd2, 32'd0, 1'b0));
    exp_q.push_back(exp_pkt(4'd1, 2'd2, 2'd1, 32'd2, 1'b0));
    repeat (30) @(negedge clk);
    chk("filter_count", 64'(got_q.size()), 64'd2);
    for (int i = 0; i < 2 && i < got_q.size(); i++)
      chk($sformatf("filter_rsp%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

    // back-pressure: five held (one in flight plus a full FIFO), sixth blocked
    got_q.delete();
    exp_q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(2'(i), 4'd1, 32'(i), 32'd100, ok);
      chk($sformatf("bp_accept%0d", i), 64'(ok), 64'd1);
      exp_q.push_back(exp_pkt(4'd1, 2'(i), 2'd1, 32'(100 + i), 1'b0));
    end
    req_paket = {2'd1, 4'd1, 32'd5, 32'd100};
    repeat (3) @(negedge clk);
    chk("bp_req_ready_low", 64'(req_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    held = rsp_paket;
    repeat (6) @(negedge clk);
    chk("bp_rsp_stable", 64'(rsp_paket), 64'(held));
    chk("bp_first_pkt", 64'(held), 64'(exp_pkt(4'd1, 2'd0, 2'd1, 32'd100, 1'b0)));
    chk("bp_still_blocked", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    send(2'd1, 4'd1, 32'd5, 32'd100, ok);
    req_valid = 1'b0;
    chk("bp_accept5", 64'(ok), 64'd1);
    exp_q.push_back(exp_pkt(4'd1, 2'd1, 2'd1, 32'd105, 1'b0));
    waited = 0;
    while (got_q.size() < 6 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("bp_count", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("bp_rsp%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

    // reset during a long shift with a second request queued behind it
    send(2'd1, 4'd6, 32'h8000_0000, 32'h0000_001F, ok);
    send(2'd0, 4'd1, 32'd4, 32'd4, ok);
    req_valid = 1'b0;
    waited = 0;
    while (state_dbg != ST_SHIFT && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_saw_shift", 64'(state_dbg == ST_SHIFT), 64'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_state_idle", 64'(state_dbg), 64'(ST_IDLE));
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    repeat (60) @(negedge clk);
    chk("rst_no_stale", 64'(got_q.size()), 64'd0);
    chk("rst_rsp_paket_clear", 64'(rsp_paket), 64'd0);
    run_vec('{2'd3, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5, 1'b0, 3}, "rst_fresh_add");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
